mem_stage_pipe: RTL

Parametrised memory-access pipeline stage between EX/MEM and writeback. It resolves the branch decision, performs byte/half/word loads and stores against a local word-organised data memory with a configurable access latency, and registers results into a MEM/WB pipeline register with a valid bit. While a multi-cycle access is in flight it stalls upstream. Unlike the single-cycle stage it replaces, it adds sub-word accesses, misalignment trapping and wait states.

---
 rtl/mem_stage_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_pipe.sv
// Memory-access pipeline stage: branch resolve, sub-word loads/stores against a
// local word-organised memory with configurable latency, and a MEM/WB register.
module mem_stage_pipe #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned REG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             stall,
    input  logic             mem_br,
    input  logic             zero,
    input  logic             write_en,
    input  logic             read_en,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [31:0]      data_address,
    input  logic [31:0]      write_data,
    input  logic [1:0]       mem_wb,
    input  logic [REG_W-1:0] dest,
    output logic             pc_src,
    output logic             wb_valid,
    output logic [1:0]       wb,
    output logic [31:0]      wb_address,
    output logic [31:0]      wb_data,
    output logic [REG_W-1:0] write_register,
    output logic             misaligned
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] LatM1 = 4'(MEM_LAT - 1);
    localparam bit SingleCycle = (MEM_LAT == 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Request held while a multi-cycle access is in flight
    logic             h_we_q, h_re_q, h_sext_q;
    logic [1:0]       h_size_q, h_wb_q;
    logic [31:0]      h_addr_q, h_wdata_q;
    logic [REG_W-1:0] h_dest_q;

    logic             wb_valid_q, mis_q;
    logic [1:0]       wb_q;
    logic [31:0]      wb_addr_q, wb_data_q;
    logic [REG_W-1:0] wb_dest_q;

    logic [31:0] mem_q [DEPTH];

    logic accept, mem_op, latch_req, busy, exec;
    logic             x_we, x_re, x_sext, x_mis;
    logic [1:0]       x_size, x_wb;
    logic [31:0]      x_addr, x_wdata;
    logic [REG_W-1:0] x_dest;
    logic [AW-1:0]    idx;
    logic [31:0]      rd_word, wr_word, wr_lanes, ld_data;
    logic [3:0]       be;
    logic             mem_we;

    assign busy      = (state_q == StBusy);
    assign stall     = busy;
    assign accept    = in_valid & ~busy;
    assign mem_op    = write_en | read_en;
    assign pc_src    = accept & mem_br & zero;
    assign latch_req = accept & mem_op & ~SingleCycle;
    assign exec      = (accept & (~mem_op | SingleCycle)) | (busy & (cnt_q == 4'd1));

    // Select the request being executed: held copy while busy, live inputs otherwise
    always_comb begin
        if (busy) begin
            x_we = h_we_q;  x_re = h_re_q;  x_sext = h_sext_q;  x_size = h_size_q;
            x_addr = h_addr_q;  x_wdata = h_wdata_q;  x_wb = h_wb_q;  x_dest = h_dest_q;
        end else begin
            x_we = write_en;  x_re = read_en;  x_sext = sign_ext;  x_size = size;
            x_addr = data_address;  x_wdata = write_data;  x_wb = mem_wb;  x_dest = dest;
        end
    end

    assign idx     = x_addr[AW+1:2];
    assign rd_word = mem_q[idx];
    assign x_mis   = (x_we | x_re) &
                     (((x_size == 2'b01) & x_addr[0]) | (x_size[1] & (|x_addr[1:0])));
    assign mem_we  = exec & x_we & ~x_mis;

    // Lane enables, store-data replication and load extraction/extension
    always_comb begin
        be       = 4'b1111;
        wr_lanes = x_wdata;
        ld_data  = rd_word;
        unique case (x_size)
            2'b00: begin
                be       = 4'b0001 << x_addr[1:0];
                wr_lanes = {4{x_wdata[7:0]}};
                ld_data  = {24'b0, 8'(rd_word >> {x_addr[1:0], 3'b000})};
                if (x_sext) ld_data[31:8] = {24{ld_data[7]}};
            end
            2'b01: begin
                be       = x_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{x_wdata[15:0]}};
                ld_data  = {16'b0, x_addr[1] ? rd_word[31:16] : rd_word[15:0]};
                if (x_sext) ld_data[31:16] = {16{ld_data[15]}};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_word[i*8 +: 8] = be[i] ? wr_lanes[i*8 +: 8] : rd_word[i*8 +: 8];
        end
        if (!x_re || x_we || x_mis) ld_data = 32'b0;
    end

    // Data memory: no reset; a store executing while reset is asserted is dropped
    always_ff @(posedge clk) begin
        if (rst && mem_we) mem_q[idx] <= wr_word;
    end

    // FSM next state and latency counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (latch_req) begin
                    state_d = StBusy;
                    cnt_d   = LatM1;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, holding register and MEM/WB register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            h_we_q     <= 1'b0;
            h_re_q     <= 1'b0;
            h_sext_q   <= 1'b0;
            h_size_q   <= 2'b0;
            h_wb_q     <= 2'b0;
            h_addr_q   <= 32'b0;
            h_wdata_q  <= 32'b0;
            h_dest_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= 2'b0;
            wb_addr_q  <= 32'b0;
            wb_data_q  <= 32'b0;
            wb_dest_q  <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= exec;
            if (latch_req) begin
                h_we_q    <= write_en;
                h_re_q    <= read_en;
                h_sext_q  <= sign_ext;
                h_size_q  <= size;
                h_wb_q    <= mem_wb;
                h_addr_q  <= data_address;
                h_wdata_q <= write_data;
                h_dest_q  <= dest;
            end
            if (exec) begin
                wb_q      <= x_mis ? 2'b00 : x_wb;
                wb_addr_q <= x_addr;
                wb_data_q <= ld_data;
                wb_dest_q <= x_dest;
                mis_q     <= x_mis;
            end
        end
    end

    assign wb_valid       = wb_valid_q;
    assign wb             = wb_q;
    assign wb_address     = wb_addr_q;
    assign wb_data        = wb_data_q;
    assign write_register = wb_dest_q;
    assign misaligned     = mis_q;

endmodule
